// File: rtl/clint.sv
// clint: core-local interruptor exposing msip, mtimecmp and mtime on a req/ack register bus.
// Define CLINT_PRESCALER_EN to advance mtime once every PRESCALE clocks instead of every clock.
module clint #(
    parameter int DATA_SIZE = 64,
    parameter int PRESCALE  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [15:0]            addr,
    input  logic [DATA_SIZE/8-1:0] sel,
    input  logic [DATA_SIZE-1:0]   wr_data,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   ack,
    output logic                   msip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);

    if (DATA_SIZE != 32 && DATA_SIZE != 64) begin : g_bad_width
        $error("clint: DATA_SIZE must be 32 or 64");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("clint: PRESCALE must be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StAck} state_e;
    state_e state;

    logic [63:0]          wdata64;
    logic [7:0]           be_cmp;
    logic [7:0]           be_mtime;
    logic                 hit_msip;
    logic                 hit_mtime;
    logic [DATA_SIZE-1:0] rd_next;
    logic                 wr;
    logic                 tick;

    assign wr       = (state == StIdle) && req && we;
    assign hit_msip = (addr == 16'h0000);

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Byte enables are widened to a 64-bit register view so one merge serves both bus widths.
    if (DATA_SIZE == 64) begin : g_bus64
        always_comb begin
            wdata64   = wr_data;
            hit_mtime = (addr == 16'hBFF8);
            be_mtime  = hit_mtime ? sel : 8'h00;
            be_cmp    = (addr == 16'h4000) ? sel : 8'h00;
            case (addr)
                16'h0000: rd_next = {{(DATA_SIZE-1){1'b0}}, msip};
                16'h4000: rd_next = mtimecmp;
                16'hBFF8: rd_next = mtime;
                default:  rd_next = '0;
            endcase
        end
    end else begin : g_bus32
        always_comb begin
            wdata64   = {wr_data, wr_data};
            hit_mtime = (addr == 16'hBFF8) || (addr == 16'hBFFC);
            be_mtime  = (addr == 16'hBFF8) ? {4'h0, sel} :
                        (addr == 16'hBFFC) ? {sel, 4'h0} : 8'h00;
            be_cmp    = (addr == 16'h4000) ? {4'h0, sel} :
                        (addr == 16'h4004) ? {sel, 4'h0} : 8'h00;
            case (addr)
                16'h0000: rd_next = {{(DATA_SIZE-1){1'b0}}, msip};
                16'h4000: rd_next = mtimecmp[31:0];
                16'h4004: rd_next = mtimecmp[63:32];
                16'hBFF8: rd_next = mtime[31:0];
                16'hBFFC: rd_next = mtime[63:32];
                default:  rd_next = '0;
            endcase
        end
    end

`ifdef CLINT_PRESCALER_EN
    localparam int CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [CntW-1:0] pre_cnt;

    assign tick = (pre_cnt == CntW'(PRESCALE - 1));

    always_ff @(posedge clock) begin
        if (reset || (wr && hit_mtime) || tick) pre_cnt <= '0;
        else                                    pre_cnt <= pre_cnt + 1'b1;
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StIdle;
            ack      <= 1'b0;
            rd_data  <= '0;
            msip     <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            case (state)
                StIdle: begin
                    if (req) begin
                        state   <= StAck;
                        ack     <= 1'b1;
                        rd_data <= rd_next;
                    end
                end
                default: begin
                    state   <= StIdle;
                    ack     <= 1'b0;
                    rd_data <= '0;
                end
            endcase
            if (wr && hit_msip && sel[0]) msip <= wr_data[0];
            if (wr) mtimecmp <= merge(mtimecmp, wdata64, be_cmp);
            // A write to either mtime half replaces this cycle's increment; the other half holds.
            if (wr && hit_mtime) mtime <= merge(mtime, wdata64, be_mtime);
            else if (tick)       mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_clint.sv
// Randomized bench for clint: a 64-bit and a 32-bit instance checked against a cycle-count model.
module tb_clint;
    localparam int PRESCALE = 4;
`ifdef CLINT_PRESCALER_EN
    localparam int P = PRESCALE;
`else
    localparam int P = 1;
`endif

    logic        clock, reset;
    logic        req, we;
    logic [15:0] addr;
    logic [7:0]  sel;
    logic [63:0] wr_data, rd_data, mtime, mtimecmp;
    logic        ack, msip;

    logic        req32, we32;
    logic [15:0] addr32;
    logic [3:0]  sel32;
    logic [31:0] wr_data32, rd_data32;
    logic [63:0] mtime32, mtimecmp32;
    logic        ack32, msip32;

    clint #(.DATA_SIZE(64), .PRESCALE(PRESCALE)) dut64 (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .sel(sel),
        .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .msip(msip), .mtime(mtime),
        .mtimecmp(mtimecmp)
    );

    clint #(.DATA_SIZE(32), .PRESCALE(PRESCALE)) dut32 (
        .clock(clock), .reset(reset), .req(req32), .we(we32), .addr(addr32), .sel(sel32),
        .wr_data(wr_data32), .rd_data(rd_data32), .ack(ack32), .msip(msip32), .mtime(mtime32),
        .mtimecmp(mtimecmp32)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    longint cyc;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks;
    int n_errors;

    // Model: mtime = value set at the last reset/write edge plus elapsed edges / P.
    logic [63:0] m_base [2];
    longint      m_cyc  [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_mtime(input int id, input longint n);
        return m_base[id] + 64'((n - m_cyc[id]) / P);
    endfunction

    function automatic void model_access(input int id, input bit w, input logic [15:0] a,
                                         input logic [7:0] s, input logic [63:0] d,
                                         input longint e, output logic [63:0] rd);
        logic [63:0] old, mask, dd;
        bit is_cmp, is_mt, hi;
        old  = exp_mtime(id, e - 1);
        mask = '0;
        if (id == 0) begin
            is_cmp = (a == 16'h4000);
            is_mt  = (a == 16'hBFF8);
            for (int i = 0; i < 8; i++) if (s[i]) mask[8*i +: 8] = 8'hFF;
            dd = d;
            rd = (a == 16'h0000) ? {63'd0, m_msip[id]} : is_cmp ? m_cmp[id] : is_mt ? old : 64'd0;
        end else begin
            is_cmp = (a == 16'h4000) || (a == 16'h4004);
            is_mt  = (a == 16'hBFF8) || (a == 16'hBFFC);
            hi     = a[2];
            for (int i = 0; i < 4; i++) if (s[i]) mask[8*i +: 8] = 8'hFF;
            if (hi) mask = mask << 32;
            dd = hi ? (d << 32) : (d & 64'hFFFF_FFFF);
            if (a == 16'h0000) rd = {63'd0, m_msip[id]};
            else if (is_cmp)   rd = hi ? (m_cmp[id] >> 32) : (m_cmp[id] & 64'hFFFF_FFFF);
            else if (is_mt)    rd = hi ? (old >> 32) : (old & 64'hFFFF_FFFF);
            else               rd = 64'd0;
        end
        if (w) begin
            if (a == 16'h0000 && s[0]) m_msip[id] = d[0];
            if (is_cmp) m_cmp[id] = (m_cmp[id] & ~mask) | (dd & mask);
            if (is_mt) begin
                m_base[id] = (old & ~mask) | (dd & mask);
                m_cyc[id]  = e;
            end
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_regs(input int id);
        if (id == 0) begin
            check_eq("msip64", {63'd0, msip}, {63'd0, m_msip[0]});
            check_eq("mtimecmp64", mtimecmp, m_cmp[0]);
            check_eq("mtime64", mtime, exp_mtime(0, cyc));
        end else begin
            check_eq("msip32", {63'd0, msip32}, {63'd0, m_msip[1]});
            check_eq("mtimecmp32", mtimecmp32, m_cmp[1]);
            check_eq("mtime32", mtime32, exp_mtime(1, cyc));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            check_eq("ack64_idle", {63'd0, ack}, 64'd0);
            check_regs(0);
            check_regs(1);
        end
    endtask

    task automatic drop_req();
        req   = 1'b0;
        req32 = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drop_req();
        repeat (n) step();
        reset = 1'b0;
        for (int id = 0; id < 2; id++) begin
            m_base[id] = '0;
            m_cyc[id]  = cyc;
            m_cmp[id]  = '1;
            m_msip[id] = 1'b0;
        end
    endtask

    // One complete transfer; hold keeps req high through the ACK cycle, where it must be ignored.
    task automatic bus(input int id, input bit w, input logic [15:0] a, input logic [7:0] s,
                       input logic [63:0] d, input bit hold);
        logic [63:0] exp_rd;
        if (id == 0) begin
            req = 1'b1; we = w; addr = a; sel = s; wr_data = d;
        end else begin
            req32 = 1'b1; we32 = w; addr32 = a; sel32 = s[3:0]; wr_data32 = d[31:0];
        end
        step();
        model_access(id, w, a, s, (id == 0) ? d : {32'd0, d[31:0]}, cyc, exp_rd);
        if (!hold) drop_req();
        check_eq("ack_high", {63'd0, (id == 0) ? ack : ack32}, 64'd1);
        if (!w) check_eq("rd_data", (id == 0) ? rd_data : {32'd0, rd_data32}, exp_rd);
        check_regs(id);
        step();
        drop_req();
        check_eq("ack_low", {63'd0, (id == 0) ? ack : ack32}, 64'd0);
        check_eq("rd_data_idle", (id == 0) ? rd_data : {32'd0, rd_data32}, 64'd0);
        check_regs(id);
    endtask

    function automatic logic [15:0] pick_addr(input int id);
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0: return 16'h0000;
            1: return 16'h4000;
            2: return 16'hBFF8;
            3: return (id == 0) ? 16'hBFF8 : 16'hBFFC;
            4: return (id == 0) ? 16'h4000 : 16'h4004;
            default: return 16'(16'h1000 + $urandom_range(0, 16'h2FFF));
        endcase
    endfunction

    initial begin
        logic [63:0] d;
        logic [7:0]  s;
        logic [15:0] a;
        cyc = 0; n_checks = 0; n_errors = 0;
        req = 0; we = 0; addr = 0; sel = 0; wr_data = 0;
        req32 = 0; we32 = 0; addr32 = 0; sel32 = 0; wr_data32 = 0;
        reset = 1'b1;

        do_reset(3);
        check_eq("rst_ack", {63'd0, ack}, 64'd0);
        check_eq("rst_rd_data", rd_data, 64'd0);
        check_eq("rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check_regs(0);
        idle(10);
        check_eq("mtime_after_10", mtime, 64'(10 / P));

        bus(0, 1'b1, 16'h0000, 8'hFF, 64'h1, 1'b0);
        bus(0, 1'b0, 16'h0000, 8'hFF, 64'h0, 1'b0);

        bus(0, 1'b1, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        idle(3);

        bus(1, 1'b1, 16'hBFF8, 8'h0F, 64'hFFFF_FFFF, 1'b0);
        idle(P + 1);
        bus(1, 1'b0, 16'hBFFC, 8'h0F, 64'h0, 1'b0);

        bus(0, 1'b0, 16'h1234, 8'hFF, 64'h0, 1'b0);
        bus(0, 1'b1, 16'h1234, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b1);

        for (int t = 0; t < 120; t++) begin
            int id;
            id = (t % 3 == 2) ? 1 : 0;
            a  = pick_addr(id);
            s  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
            bus(id, $urandom_range(0, 1) == 1, a, s, d, $urandom_range(0, 1) == 1);
            idle($urandom_range(0, 2));
        end

        // Reset landing on the ACK cycle must abort the transfer.
        req = 1'b1; we = 1'b1; addr = 16'h0000; sel = 8'hFF; wr_data = 64'h1;
        step();
        check_eq("ack_before_abort", {63'd0, ack}, 64'd1);
        do_reset(1);
        check_eq("abort_ack", {63'd0, ack}, 64'd0);
        check_eq("abort_rd_data", rd_data, 64'd0);
        check_eq("abort_msip", {63'd0, msip}, 64'd0);
        check_regs(0);
        check_regs(1);
        idle(16);
        check_eq("mtime_after_16", mtime, 64'(16 / P));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, meaning bus data width (32 or 64 only).
REQ-002 SHALL have parameter PRESCALE, default 1, meaning clock cycles per mtime tick (>=1; used only per REQ-029).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  1  bus request; held high until ack.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr  input  16  byte offset within the CLINT window.
REQ-008 SHALL have port sel  input  DATA_SIZE/8  byte enables for writes.
REQ-009 SHALL have port wr_data  input  DATA_SIZE  write data.
REQ-010 SHALL have port rd_data  output  DATA_SIZE  read data, valid while ack=1.
REQ-011 SHALL have port ack  output  1  one-cycle transfer-complete pulse.
REQ-012 SHALL have port msip  output  1  machine software interrupt pending, to CSR unit.
REQ-013 SHALL have port mtime  output  64  machine timer, to CSR unit.
REQ-014 SHALL have port mtimecmp  output  64  timer compare, to CSR unit.

Function
REQ-015 SHALL decode the register map: 0x0000 msip (bit 0 only, others read 0); 0x4000 mtimecmp; 0xBFF8 mtime.
REQ-016 SHALL, when DATA_SIZE=32, map the low word at the base offset and the high word at base+4 (0x4004, 0xBFFC); when DATA_SIZE=64, access the full 64 bits at the base offset.
REQ-017 SHALL implement a two-state handshake FSM: IDLE -> ACK when req=1; ACK -> IDLE unconditionally.
REQ-018 SHALL assert ack for exactly one cycle in state ACK; back-to-back requests complete no faster than one per two cycles.
REQ-019 SHALL perform writes on the IDLE->ACK edge, updating only the bytes with sel[i]=1.
REQ-020 SHALL register rd_data on the IDLE->ACK edge; rd_data SHALL be 0 whenever ack=0.
REQ-021 SHALL treat unmapped offsets as ack-with-rd_data=0; writes to them are ignored; no error signal.
REQ-022 SHALL increment mtime by 1 per tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-023 SHALL give a bus write to mtime priority over the same-cycle increment; the written value appears unmodified on the next cycle, and increments resume the cycle after.
REQ-024 SHALL, for DATA_SIZE=32, treat each half-write independently; a carry from the low to the high word in a non-write cycle SHALL still propagate.
REQ-025 SHALL return, on mtime reads, the value held at the sampling edge (no double-increment, no torn 64-bit read when DATA_SIZE=64).
REQ-026 SHALL drive msip, mtime and mtimecmp directly from registers (no combinational path from bus inputs).
REQ-027 SHALL ignore req deassertion while in ACK; a request withdrawn before ack has still taken effect.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set: FSM=IDLE, ack=0, rd_data=0, msip=0, mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, prescaler count=0; reset mid-transfer aborts it with no ack.

Configuration
REQ-029 SHALL, with macro CLINT_PRESCALER_EN defined, tick mtime once every PRESCALE cycles using a counter 0..PRESCALE-1; a write to mtime clears the counter; PRESCALE=1 behaves as without the macro.
REQ-030 SHALL, without CLINT_PRESCALER_EN, tick mtime every cycle, ignore PRESCALE, and contain no prescaler counter.

Verification
REQ-031 SHALL cover: reset released, 10 idle cycles -> mtime=10, mtimecmp=all-ones, msip=0, ack=0.
REQ-032 SHALL cover: write 0x1 to 0x0000 with sel all-ones -> ack one cycle later, msip=1; read 0x0000 -> rd_data=1.
REQ-033 SHALL cover: write mtime=0xFFFF_FFFF_FFFF_FFFE (DATA_SIZE=64) -> next cycle 0x...FE, then 0x...FF, then 0x0.
REQ-034 SHALL cover: DATA_SIZE=32, write 0xFFFF_FFFF to 0xBFF8 with mtime high=0 -> two cycles later mtime=0x0000_0001_0000_0000.
REQ-035 SHALL cover: read 0x1234 -> ack=1, rd_data=0; write to 0x1234 -> no register changes.
REQ-036 SHALL cover: CLINT_PRESCALER_EN, PRESCALE=4, 16 cycles after reset -> mtime=4; reset asserted during ACK -> ack stays 0.
